// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one data-memory port between two masters: the core load/store unit
// (M0) and the debug/program-loader port (M1). One transaction is in flight
// at a time. Ties are broken round-robin using the last granted master. The
// winner's payload is forwarded to the memory, and the memory acknowledge,
// or a timeout error, is routed back to that master only.
//
// Parameters
//   AW       address width
//   DW       data width (byte enables are DW/8 bits)
//   TIMEOUT  BUSY cycles allowed without s_ack before aborting (1..65535)
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   m0_* / m1_*                 master request side (req/we/addr/wdata/be in,
//                               rdata/ack/err out)
//   s_req/s_we/s_addr/
//   s_wdata/s_be                request to the memory, muxed from the owner
//   s_rdata, s_ack              memory response
//   gnt_id                      registered owner (0 = M0, 1 = M1)
//   busy                        high while a transaction is in flight
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_ack,
  output logic            m0_err,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_ack,
  output logic            m1_err,

  output logic            s_req,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_be,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_ack,

  output logic            gnt_id,
  output logic            busy
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  // Counter value seen on BUSY cycle number TIMEOUT (counter starts at 0).
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_BUSY  = 1'b1;

  logic [0:0]    r_state;
  logic          r_owner;
  logic          r_last;
  logic [CW-1:0] r_cnt;

  logic          w_busy;
  logic          w_sel1;
  logic          w_cntEnd;
  logic          w_timeout;
  logic          w_anyReq;
  logic          w_grantId;

  assign w_busy    = (r_state == ST_BUSY);
  // In IDLE the payload mux rests on M0; s_req is low so the memory ignores it.
  assign w_sel1    = w_busy & r_owner;
  assign w_cntEnd  = (r_cnt == CNT_LAST);
  // An ack on the final allowed cycle takes priority over the timeout.
  assign w_timeout = w_busy & ~s_ack & w_cntEnd;
  assign w_anyReq  = m0_req | m1_req;
  // M1 wins when it is alone, or when both request and M0 was granted last.
  assign w_grantId = m1_req & (~m0_req | ~r_last);

  // Arbitration / transaction FSM. Reset leaves last = 1 so M0 wins the
  // first tie; an asynchronous reset mid-transaction silently drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_anyReq) begin
        r_state <= ST_BUSY;
        r_owner <= w_grantId;
        r_last  <= w_grantId;
        r_cnt   <= '0;
      end
    end else begin
      if (s_ack || w_cntEnd) begin
        r_state <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign s_req    = w_busy;
  assign s_we     = w_sel1 ? m1_we    : m0_we;
  assign s_addr   = w_sel1 ? m1_addr  : m0_addr;
  assign s_wdata  = w_sel1 ? m1_wdata : m0_wdata;
  assign s_be     = w_sel1 ? m1_be    : m0_be;

  // Read data is broadcast; it is only meaningful alongside the ack pulse.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  // s_ack outside BUSY (e.g. a late ack after a timeout) is ignored.
  assign m0_ack   = w_busy & s_ack & ~r_owner;
  assign m1_ack   = w_busy & s_ack &  r_owner;
  assign m0_err   = w_timeout & ~r_owner;
  assign m1_err   = w_timeout &  r_owner;

  assign gnt_id   = r_owner;
  assign busy     = w_busy;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter that shares the SoC data-memory port between the core load/store unit (M0) and the debug/program-loader port (M1). It accepts one transaction at a time, grants round-robin, forwards the winner's request to the memory, and routes the acknowledge or a timeout error back to the owner. It sits between `riscv_soc`'s core and its data RAM, so the bench can preload or inspect memory while the core runs.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width; byte enables are `DW/8` bits wide.
- `TIMEOUT`, default 255: maximum BUSY cycles without `s_ack` before the transaction is aborted. Legal range is 1 to 65535.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req` / `m1_req` in 1: transaction request; held stable with its payload until `mX_ack` or `mX_err`.
- `m0_we` / `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr` / `m1_addr` in AW: byte address.
- `m0_wdata` / `m1_wdata` in DW: write data.
- `m0_be` / `m1_be` in DW/8: byte enables.
- `m0_rdata` / `m1_rdata` out DW: read data; `s_rdata` is broadcast to both and is valid only with ack.
- `m0_ack` / `m1_ack` out 1: one-cycle completion pulse.
- `m0_err` / `m1_err` out 1: one-cycle timeout pulse.
- `s_req` out 1: request to the memory.
- `s_we` out 1: write strobe to the memory, muxed from the owner.
- `s_addr` out AW: address to the memory, muxed from the owner.
- `s_wdata` out DW: write data to the memory, muxed from the owner.
- `s_be` out DW/8: byte enables to the memory, muxed from the owner.
- `s_rdata` in DW: memory read data.
- `s_ack` in 1: memory completion; valid only while `s_req` = 1.
- `gnt_id` out 1: registered owner, 0 = M0, 1 = M1.
- `busy` out 1: 1 while in BUSY.

## Operation
- **Registered state:** FSM {IDLE, BUSY}, `owner`, `last` (last granted master), and a timeout counter of `$clog2(TIMEOUT+1)` bits.
- **IDLE:**
  - No request pending: stay in IDLE.
  - Exactly one request pending: grant that master.
  - Both requests pending: grant `!last`.
  - On a grant: `owner` and `last` take the granted id, the counter clears, and the state goes to BUSY.
- **BUSY:**
  - `s_req` = 1, and `s_we`/`s_addr`/`s_wdata`/`s_be` are combinationally muxed from `owner`.
  - `mX_ack` = `s_ack & (owner == X)`, combinational in the same cycle.
  - On `s_ack`: return to IDLE.
  - Else if counter == TIMEOUT-1: pulse the owner's `err` that cycle and return to IDLE.
  - Else: increment the counter.
- **Non-owner:** always sees ack = 0 and err = 0. Its request stays pending and is not dropped.
- **Outside BUSY:** `s_ack` is ignored, including a late ack after a timeout.
- **Idle outputs:** in IDLE, `s_req` = 0 and the slave payload outputs show M0's signals (don't-care for the memory).
- **Fairness:** with both masters requesting continuously, grants strictly alternate.

## Timing
- **Reset values (asynchronous):** state IDLE, `owner` 0, `last` 1 (so M0 wins the first tie), counter 0.
  - Outputs in reset: `s_req` 0, `busy` 0, `gnt_id` 0, all ack/err 0.
- **Reset asserted mid-BUSY:** `s_req` drops immediately and no ack/err is delivered. The master must reissue its request.
- **Sequence for a request sampled in IDLE at cycle t:**
  - t+1: BUSY, `s_req` = 1.
  - Earliest ack: t+1, for a zero-wait memory.
  - Cycle after ack/err: IDLE.
- **Turnaround:** one mandatory IDLE cycle between transactions, so minimum occupancy is 2 + memory wait cycles.
- **Back-to-back requests:** a master may hold `req` high in the cycle after its ack to request again; that cycle is IDLE and arbitrates normally.
- **Timeout:** err fires on BUSY cycle number TIMEOUT, counting from 1, when no ack has arrived. `s_req` is low in the next cycle.
- **Ack coincident with the timeout cycle:** ack wins and no err is raised.
- **TIMEOUT = 1:** err fires on the first BUSY cycle unless `s_ack` is present.

## Test plan
- **Reset:** assert `rst` with random inputs, then hold → `s_req`, `busy`, `gnt_id`, all ack/err = 0. Deassert → still IDLE until a request arrives.
- **Single write:** M0 write to 0x0000_0100, data 0x1234_5678, be 0xF, zero-wait memory →
  - `s_req` = 1 with those values one cycle after `req`;
  - `m0_ack` in the same cycle;
  - `busy` = 0 in the next cycle.
- **Contention:** both masters request continuously for 6 transactions → `gnt_id` sequence 0,1,0,1,0,1. Every ack goes only to the matching master.
- **Wait states:** memory acks on the 3rd BUSY cycle with `s_rdata` 0xDEAD_BEEF for an M1 read →
  - `m1_ack` pulses once with `m1_rdata` 0xDEAD_BEEF;
  - `m0_ack` stays 0;
  - a pending M0 request is served next.
- **Timeout (TIMEOUT = 8), no `s_ack`:**
  - `m0_err` pulses on BUSY cycle 8 and `s_req` = 0 in the next cycle.
  - A late `s_ack` in IDLE → no ack.
- **Timeout edge and reset abort (TIMEOUT = 8):**
  - `s_ack` on BUSY cycle 8 → ack = 1, err = 0.
  - Separately, `rst` asserted on BUSY cycle 2 → `s_req` = 0 asynchronously and no ack/err; after release an M1 request wins normally.
